// File: rtl/pe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_ctrl_pkg
// Brief    : Shared command and state encodings for pe_array and its
//            host-side sequencing controller (pe_array_ctrl).
// Revision : 1.0  initial release
// ============================================================================
package pe_ctrl_pkg;

  // Command bus into pe_array
  localparam int                     PE_CMD_BITS    = 2;
  localparam logic [PE_CMD_BITS-1:0] PE_CMD_NOP     = 2'd0;
  localparam logic [PE_CMD_BITS-1:0] PE_CMD_WRITE   = 2'd1;
  localparam logic [PE_CMD_BITS-1:0] PE_CMD_PROCESS = 2'd2;

  // Cell state encodings
  localparam logic PE_STATE_DEAD = 1'b0;
  localparam logic PE_STATE_LIVE = 1'b1;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PROCESS   = 3'd1,
    ST_SCAN_ADDR = 3'd2,
    ST_SCAN_CAP  = 3'd3,
    ST_SCAN_OUT  = 3'd4,
    ST_DONE      = 3'd5
  } pe_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/pe_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : pe_scan_counter
// Brief    : Raster x/y counter (x inner, y outer) with clear/advance and a
//            flag marking the final cell of the array. Also exposes the
//            coordinates of the following cell so the owner can register
//            the next address on the same edge that the counter advances.
// Revision : 1.0  initial release
// ============================================================================
module pe_scan_counter #(
  parameter int N_PX   = 4,
  parameter int N_PY   = 4,
  parameter int X_BITS = $clog2(N_PX),
  parameter int Y_BITS = $clog2(N_PY)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [X_BITS-1:0] x_o,
  output logic [Y_BITS-1:0] y_o,
  output logic [X_BITS-1:0] nx_o,
  output logic [Y_BITS-1:0] ny_o,
  output logic              last_o
);

  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(N_PX - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(N_PY - 1);

  logic [X_BITS-1:0] x_q;
  logic [Y_BITS-1:0] y_q;
  logic              x_wrap;

  // Next-cell coordinates: x wraps at the row end and carries into y
  always_comb begin
    x_wrap = (x_q == X_MAX);
    last_o = x_wrap && (y_q == Y_MAX);
    nx_o   = x_wrap ? '0 : x_q + X_BITS'(1);
    if (last_o) begin
      ny_o = '0;
    end else if (x_wrap) begin
      ny_o = y_q + Y_BITS'(1);
    end else begin
      ny_o = y_q;
    end
  end

  // Counter register: clear has priority over advance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clr_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (adv_i) begin
      x_q <= nx_o;
      y_q <= ny_o;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule
`default_nettype wire

// File: rtl/pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_array_ctrl
// Brief    : Host-side sequencer for pe_array. Writes host cell beats into
//            the array, runs a requested number of Life generations, then
//            raster-scans the array and streams each cell on a valid/ready
//            port. Build option PE_CTRL_SKIP_DEAD_EN streams live cells only.
// Revision : 1.0  initial release
// ============================================================================
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int N_PX       = 4,
  parameter int N_PY       = 4,
  parameter int STATE_BITS = 1,
  parameter int GEN_BITS   = 8,
  parameter int X_BITS     = $clog2(N_PX),
  parameter int Y_BITS     = $clog2(N_PY)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_valid_i,
  output logic                   load_ready_o,
  input  logic [X_BITS-1:0]      load_x_i,
  input  logic [Y_BITS-1:0]      load_y_i,
  input  logic [STATE_BITS-1:0]  load_state_i,
  input  logic                   run_start_i,
  input  logic [GEN_BITS-1:0]    run_gens_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [X_BITS-1:0]      rd_x_o,
  output logic [Y_BITS-1:0]      rd_y_o,
  output logic [STATE_BITS-1:0]  rd_state_o,
  output logic [PE_CMD_BITS-1:0] cmd_o,
  output logic [X_BITS-1:0]      adr_x_o,
  output logic [Y_BITS-1:0]      adr_y_o,
  output logic [STATE_BITS-1:0]  state_in_o,
  input  logic [STATE_BITS-1:0]  state_out_i
);

  pe_ctrl_state_e         state_q, state_d;
  logic [GEN_BITS-1:0]    gen_q, gen_d;
  logic [PE_CMD_BITS-1:0] cmd_q, cmd_d;
  logic [X_BITS-1:0]      adr_x_q, adr_x_d;
  logic [Y_BITS-1:0]      adr_y_q, adr_y_d;
  logic [STATE_BITS-1:0]  state_in_q, state_in_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [X_BITS-1:0]      rd_x_q, rd_x_d;
  logic [Y_BITS-1:0]      rd_y_q, rd_y_d;
  logic [STATE_BITS-1:0]  rd_state_q, rd_state_d;

  logic                   cnt_clr, cnt_adv, cnt_last;
  logic [X_BITS-1:0]      cnt_x, cnt_nx;
  logic [Y_BITS-1:0]      cnt_y, cnt_ny;
  logic                   skip_cell;

  pe_scan_counter #(
    .N_PX   (N_PX),
    .N_PY   (N_PY),
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_scan_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .adv_i  (cnt_adv),
    .x_o    (cnt_x),
    .y_o    (cnt_y),
    .nx_o   (cnt_nx),
    .ny_o   (cnt_ny),
    .last_o (cnt_last)
  );

  // Dead cells are dropped from the stream only when the filter is built in
`ifdef PE_CTRL_SKIP_DEAD_EN
  assign skip_cell = (state_out_i == STATE_BITS'(PE_STATE_DEAD));
`else
  assign skip_cell = 1'b0;
`endif

  // Loads are only taken in IDLE, and a same-cycle run request wins
  assign load_ready_o = rst_ni && (state_q == ST_IDLE) && !run_start_i;

  // Next-state and registered-output logic for the whole sequence
  always_comb begin
    state_d    = state_q;
    gen_d      = gen_q;
    cmd_d      = PE_CMD_NOP;
    adr_x_d    = adr_x_q;
    adr_y_d    = adr_y_q;
    state_in_d = state_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_x_d     = rd_x_q;
    rd_y_d     = rd_y_q;
    rd_state_d = rd_state_q;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run_start_i) begin
          gen_d   = run_gens_i;
          busy_d  = 1'b1;
          cnt_clr = 1'b1;
          adr_x_d = '0;
          adr_y_d = '0;
          if (run_gens_i != '0) begin
            state_d = ST_PROCESS;
            cmd_d   = PE_CMD_PROCESS;
          end else begin
            state_d = ST_SCAN_ADDR;
          end
        end else if (load_valid_i) begin
          cmd_d      = PE_CMD_WRITE;
          adr_x_d    = load_x_i;
          adr_y_d    = load_y_i;
          state_in_d = load_state_i;
        end
      end
      ST_PROCESS: begin
        // gen_q counts the PROCESS cycles still to issue, this one included
        gen_d = gen_q - GEN_BITS'(1);
        if (gen_q <= GEN_BITS'(1)) begin
          state_d = ST_SCAN_ADDR;
        end else begin
          cmd_d = PE_CMD_PROCESS;
        end
      end
      ST_SCAN_ADDR: begin
        state_d = ST_SCAN_CAP;
      end
      ST_SCAN_CAP: begin
        if (skip_cell) begin
          if (cnt_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_adv = 1'b1;
            adr_x_d = cnt_nx;
            adr_y_d = cnt_ny;
            state_d = ST_SCAN_ADDR;
          end
        end else begin
          rd_x_d     = cnt_x;
          rd_y_d     = cnt_y;
          rd_state_d = state_out_i;
          rd_valid_d = 1'b1;
          state_d    = ST_SCAN_OUT;
        end
      end
      ST_SCAN_OUT: begin
        if (rd_valid_q && rd_ready_i) begin
          rd_valid_d = 1'b0;
          if (cnt_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_adv = 1'b1;
            adr_x_d = cnt_nx;
            adr_y_d = cnt_ny;
            state_d = ST_SCAN_ADDR;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gen_q      <= '0;
      cmd_q      <= PE_CMD_NOP;
      adr_x_q    <= '0;
      adr_y_q    <= '0;
      state_in_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_state_q <= '0;
    end else begin
      state_q    <= state_d;
      gen_q      <= gen_d;
      cmd_q      <= cmd_d;
      adr_x_q    <= adr_x_d;
      adr_y_q    <= adr_y_d;
      state_in_q <= state_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      rd_state_q <= rd_state_d;
    end
  end

  assign cmd_o      = cmd_q;
  assign adr_x_o    = adr_x_q;
  assign adr_y_o    = adr_y_q;
  assign state_in_o = state_in_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_x_o     = rd_x_q;
  assign rd_y_o     = rd_y_q;
  assign rd_state_o = rd_state_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_array_ctrl
// Brief    : Directed bench for pe_array_ctrl with a 4x4 behavioural
//            pe_array model (bounded Life, registered read port).
//            Honours PE_CTRL_SKIP_DEAD_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_pe_array_ctrl;
  import pe_ctrl_pkg::*;

`ifdef PE_CTRL_SKIP_DEAD_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // Hand-computed: horizontal blinker on row 2 becomes vertical at x=2, y=1..3
  localparam logic [15:0] EXP_GRID = 16'h4440;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [1:0] load_x = '0;
  logic [1:0] load_y = '0;
  logic       load_state = 1'b0;
  logic       run_start = 1'b0;
  logic [7:0] run_gens = '0;
  logic       busy, done, rd_valid;
  logic       rd_ready = 1'b1;
  logic [1:0] rd_x, rd_y, adr_x, adr_y;
  logic       rd_state, state_in;
  logic       state_out = 1'b0;
  logic [1:0] cmd;

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] grid = '0;
  logic [15:0] exp_grid;

  always #5 clk = ~clk;

  pe_array_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_x_i     (load_x),
    .load_y_i     (load_y),
    .load_state_i (load_state),
    .run_start_i  (run_start),
    .run_gens_i   (run_gens),
    .busy_o       (busy),
    .done_o       (done),
    .rd_valid_o   (rd_valid),
    .rd_ready_i   (rd_ready),
    .rd_x_o       (rd_x),
    .rd_y_o       (rd_y),
    .rd_state_o   (rd_state),
    .cmd_o        (cmd),
    .adr_x_o      (adr_x),
    .adr_y_o      (adr_y),
    .state_in_o   (state_in),
    .state_out_i  (state_out)
  );

  function automatic logic [15:0] life_step(input logic [15:0] g);
    logic [15:0] r;
    r = '0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (!(dx == 0 && dy == 0) && (x + dx) >= 0 && (x + dx) < 4 &&
                (y + dy) >= 0 && (y + dy) < 4) begin
              n += int'(g[(y + dy) * 4 + (x + dx)]);
            end
          end
        end
        r[y * 4 + x] = g[y * 4 + x] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return r;
  endfunction

  // Behavioural pe_array: write/process on command, read one cycle after adr
  always @(posedge clk) begin
    if (cmd == PE_CMD_WRITE) begin
      grid[{adr_y, adr_x}] <= state_in;
    end else if (cmd == PE_CMD_PROCESS) begin
      grid <= life_step(grid);
    end
    state_out <= grid[{adr_y, adr_x}];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consume one run's readout, checking each beat against the expected grid
  task automatic scan_run(input int stall_at, input int abort_at, input int first_exp);
    int beat, cyc, k, exp_n, first_cyc, n_proc;
    logic done_seen, aborted;
    beat = 0; cyc = 0; k = 0; first_cyc = -1; n_proc = 0;
    done_seen = 1'b0; aborted = 1'b0;
    exp_n = SKIP ? 3 : 16;
    rd_ready = 1'b1;
    while (!done_seen && !aborted && cyc < 300) begin
      if (cmd == PE_CMD_PROCESS) n_proc++;
      if (rd_valid) begin
        if (SKIP) begin
          while (k < 15 && !exp_grid[k]) k++;
        end
        if (first_cyc < 0) first_cyc = cyc;
        check_val($sformatf("beat%0d", beat), {27'd0, rd_y, rd_x, rd_state},
                  {27'd0, k[3:0], exp_grid[k]});
        if (beat == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_val("rst_cmd", {30'd0, cmd}, {30'd0, PE_CMD_NOP});
          check_val("rst_flags", {29'd0, busy, done, rd_valid}, 32'd0);
          check_val("rst_rd", {27'd0, rd_y, rd_x, rd_state}, 32'd0);
          check_val("rst_adr", {27'd0, adr_y, adr_x, state_in}, 32'd0);
          check_val("rst_load_ready", {31'd0, load_ready}, 32'd0);
          aborted = 1'b1;
        end else begin
          if (beat == stall_at) begin
            rd_ready = 1'b0;
            repeat (5) tick();
            check_val("stall_valid", {31'd0, rd_valid}, 32'd1);
            check_val("stall_rd", {27'd0, rd_y, rd_x, rd_state}, {27'd0, k[3:0], exp_grid[k]});
            check_val("stall_adr", {28'd0, adr_y, adr_x}, {28'd0, k[3:0]});
            rd_ready = 1'b1;
          end
          beat++;
          k++;
        end
      end
      if (!aborted) begin
        tick();
        cyc++;
        if (done) done_seen = 1'b1;
      end
    end
    if (!aborted) begin
      check_val("beat_count", beat, exp_n);
      check_val("done_seen", {31'd0, done_seen}, 32'd1);
      check_val("busy_at_done", {31'd0, busy}, 32'd0);
      check_val("no_process_in_scan", n_proc, 0);
      if (first_exp >= 0) check_val("first_beat_cycle", first_cyc, first_exp);
      tick();
      check_val("done_one_cycle", {31'd0, done}, 32'd0);
    end
  endtask

  // Pulse run_start with the given count; returns after the sampling edge
  task automatic start_run(input logic [7:0] gens);
    run_start = 1'b1;
    run_gens  = gens;
    #1;
    check_val("run_load_ready", {31'd0, load_ready}, 32'd0);
    tick();
    run_start  = 1'b0;
    load_valid = 1'b0;
    check_val("run_busy", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    exp_grid = EXP_GRID;

    // Reset held for three cycles
    repeat (3) tick();
    check_val("reset_cmd", {30'd0, cmd}, {30'd0, PE_CMD_NOP});
    check_val("reset_flags", {29'd0, busy, done, rd_valid}, 32'd0);
    check_val("reset_load_ready", {31'd0, load_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("release_load_ready", {31'd0, load_ready}, 32'd1);

    // Horizontal blinker on row 2, back-to-back beats
    for (int i = 1; i <= 3; i++) begin
      load_valid = 1'b1;
      load_x     = 2'(i);
      load_y     = 2'd2;
      load_state = PE_STATE_LIVE;
      #1;
      check_val("load_ready_beat", {31'd0, load_ready}, 32'd1);
      tick();
      check_val($sformatf("write%0d", i), {27'd0, cmd, adr_x, adr_y, state_in},
                {27'd0, PE_CMD_WRITE, 2'(i), 2'd2, PE_STATE_LIVE});
    end
    load_valid = 1'b0;
    tick();
    check_val("after_load_nop", {30'd0, cmd}, {30'd0, PE_CMD_NOP});

    // One generation, full-rate readout
    start_run(8'd1);
    check_val("gen1_process", {30'd0, cmd}, {30'd0, PE_CMD_PROCESS});
    tick();
    check_val("gen1_single_process", {30'd0, cmd}, {30'd0, PE_CMD_NOP});
    scan_run(-1, -1, SKIP ? 14 : 2);

    // Zero generations, backpressure on one beat
    start_run(8'd0);
    check_val("gen0_no_process", {30'd0, cmd}, {30'd0, PE_CMD_NOP});
    tick();
    check_val("gen0_cap_not_valid", {31'd0, rd_valid}, 32'd0);
    scan_run(SKIP ? 1 : 3, -1, SKIP ? 13 : 1);

    // run_start and load_valid together: run wins, no write; then reset mid-scan
    load_valid = 1'b1;
    load_x     = 2'd0;
    load_y     = 2'd0;
    load_state = PE_STATE_LIVE;
    start_run(8'd0);
    check_val("collide_no_write", {30'd0, cmd}, {30'd0, PE_CMD_NOP});
    scan_run(-1, SKIP ? 1 : 6, -1);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check_val("rerelease_load_ready", {31'd0, load_ready}, 32'd1);

    // Fresh run after the aborted scan restarts from (0,0)
    start_run(8'd0);
    tick();
    scan_run(-1, -1, SKIP ? 13 : 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
